// File: rtl/dvp_camera_emulator.sv
// OV7670-style DVP transmitter. Emits vsync/href/p_data as an RGB565 byte stream,
// two bytes per pixel with the high byte first. Pixels come from a frame buffer
// read port or from one of three internal test patterns.
//
// Ports:
//   p_clock      byte clock; one p_data byte per cycle
//   rst_n        asynchronous active-low reset
//   enable       start/continue frame generation
//   pattern_sel  0=frame buffer, 1=colour bars, 2=address ramp, 3=black
//   rd_en        frame buffer read strobe
//   rdaddr       frame buffer pixel address (line*H_ACTIVE + pixel)
//   rddata       frame buffer pixel, valid one cycle after rd_en
//   vsync        frame sync, active high (falling-edge registered)
//   href         line valid, active high (falling-edge registered)
//   p_data       RGB565 byte stream (falling-edge registered)
//   frame_done   one-cycle pulse on the first front-porch cycle
//   busy         high whenever a frame is in progress
module dvp_camera_emulator #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned VSYNC_LEN = 20,
  parameter int unsigned V_BACK    = 34,
  parameter int unsigned H_BLANK   = 28,
  parameter int unsigned V_FRONT   = 20
) (
  input  logic        p_clock,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        rd_en,
  output logic [18:0] rdaddr,
  input  logic [15:0] rddata,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  p_data,
  output logic        frame_done,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StVsync, StVback, StLine, StHblank, StVfront} state_e;

  localparam int unsigned BarW = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  localparam logic [15:0] VsyncLast  = 16'(VSYNC_LEN - 1);
  localparam logic [15:0] VbackLast  = 16'(V_BACK - 1);
  localparam logic [15:0] HblankLast = 16'(H_BLANK - 1);
  localparam logic [15:0] VfrontLast = 16'(V_FRONT - 1);
  // Prefetch slot for pixel 0 of a line: two cycles before the first href byte.
  localparam logic [15:0] VbackPre   = 16'(V_BACK - 2);
  localparam logic [15:0] HblankPre  = 16'(H_BLANK - 2);
  localparam logic [10:0] ByteLast   = 11'(2 * H_ACTIVE - 1);
  localparam logic [8:0]  LineLast   = 9'(V_ACTIVE - 1);
  localparam logic [18:0] AddrLast   = 19'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [10:0] BarLast    = 11'(BarW - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [10:0] byte_q;
  logic [8:0]  line_q;
  logic [1:0]  pat_q;
  logic [15:0] pix_cnt_q;
  logic [10:0] bar_px_q;
  logic [2:0]  bar_idx_q;
  logic [15:0] fb_pix_q;
  logic        rd_pend_q;
  logic [15:0] bar_colour;
  logic [15:0] pixel;
  logic [7:0]  data_core;

  // Read slots: pixel n is requested on the high-byte cycle of pixel n-1, pixel 0
  // in the second-to-last blanking cycle.
  always_comb begin
    rd_en = 1'b0;
    if (pat_q == 2'd0) begin
      unique case (state_q)
        StVback:  rd_en = (cnt_q == VbackPre);
        StHblank: rd_en = (cnt_q == HblankPre);
        StLine:   rd_en = !byte_q[0] && (byte_q < ByteLast - 11'd1);
        default:  rd_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge p_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      byte_q     <= '0;
      line_q     <= '0;
      pat_q      <= '0;
      pix_cnt_q  <= '0;
      bar_px_q   <= '0;
      bar_idx_q  <= '0;
      fb_pix_q   <= '0;
      rd_pend_q  <= 1'b0;
      rdaddr     <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      rd_pend_q  <= rd_en;
      if (rd_pend_q) fb_pix_q <= rddata;
      if (rd_en) rdaddr <= (rdaddr == AddrLast) ? '0 : rdaddr + 19'd1;

      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_q   <= StVsync;
            cnt_q     <= '0;
            pat_q     <= pattern_sel;
            rdaddr    <= '0;
            pix_cnt_q <= '0;
            busy      <= 1'b1;
          end
        end
        StVsync: begin
          if (cnt_q == VsyncLast) begin
            state_q <= StVback;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StVback: begin
          if (cnt_q == VbackLast) begin
            state_q <= StLine;
            cnt_q   <= '0;
            byte_q  <= '0;
            line_q  <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StLine: begin
          // Pixel-rate counters advance after the low byte.
          if (byte_q[0]) begin
            pix_cnt_q <= pix_cnt_q + 16'd1;
            if (bar_px_q == BarLast) begin
              bar_px_q  <= '0;
              bar_idx_q <= bar_idx_q + 3'd1;
            end else begin
              bar_px_q <= bar_px_q + 11'd1;
            end
          end
          if (byte_q == ByteLast) begin
            byte_q    <= '0;
            bar_px_q  <= '0;
            bar_idx_q <= '0;
            cnt_q     <= '0;
            if (line_q == LineLast) begin
              line_q     <= '0;
              state_q    <= StVfront;
              frame_done <= 1'b1;
            end else begin
              line_q  <= line_q + 9'd1;
              state_q <= StHblank;
            end
          end else begin
            byte_q <= byte_q + 11'd1;
          end
        end
        StHblank: begin
          if (cnt_q == HblankLast) begin
            state_q <= StLine;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StVfront: begin
          if (cnt_q == VfrontLast) begin
            cnt_q <= '0;
            if (enable) begin
              state_q   <= StVsync;
              pat_q     <= pattern_sel;
              rdaddr    <= '0;
              pix_cnt_q <= '0;
            end else begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    case (bar_idx_q)
      3'd0:    bar_colour = 16'hFFFF;
      3'd1:    bar_colour = 16'hFFE0;
      3'd2:    bar_colour = 16'h07FF;
      3'd3:    bar_colour = 16'h07E0;
      3'd4:    bar_colour = 16'hF81F;
      3'd5:    bar_colour = 16'hF800;
      3'd6:    bar_colour = 16'h001F;
      default: bar_colour = 16'h0000;
    endcase
  end

  always_comb begin
    unique case (pat_q)
      2'd0:    pixel = fb_pix_q;
      2'd1:    pixel = bar_colour;
      2'd2:    pixel = pix_cnt_q;
      default: pixel = 16'h0000;
    endcase
    data_core = 8'h00;
    if (state_q == StLine) data_core = byte_q[0] ? pixel[7:0] : pixel[15:8];
  end

  // Launch the bus on the falling edge so it is centred on the receiver's rising edge.
  always_ff @(negedge p_clock or negedge rst_n) begin
    if (!rst_n) begin
      vsync  <= 1'b0;
      href   <= 1'b0;
      p_data <= 8'h00;
    end else begin
      vsync  <= (state_q == StVsync);
      href   <= (state_q == StLine);
      p_data <= data_core;
    end
  end

endmodule

// File: tb/tb_dvp_camera_emulator.sv
module tb_dvp_camera_emulator;

  localparam int H  = 8;
  localparam int V  = 3;
  localparam int VS = 20;
  localparam int VB = 34;
  localparam int HB = 28;
  localparam int VF = 20;
  localparam int Pitch    = 2 * H + HB;
  localparam int LinesLen = V * 2 * H + (V - 1) * HB;
  localparam int FrameLen = VS + VB + LinesLen + VF;

  logic        p_clock;
  logic        rst_n;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic        rd_en;
  logic [18:0] rdaddr;
  logic [15:0] rddata;
  logic        vsync;
  logic        href;
  logic [7:0]  p_data;
  logic        frame_done;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_t    = 0;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  typedef struct packed {
    logic        vs;
    logic        hr;
    logic        re;
    logic        fd;
    logic        bz;
    logic [7:0]  pd;
    logic [18:0] ra;
  } exp_t;

  dvp_camera_emulator #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .VSYNC_LEN (VS),
    .V_BACK    (VB),
    .H_BLANK   (HB),
    .V_FRONT   (VF)
  ) u_dut (
    .p_clock     (p_clock),
    .rst_n       (rst_n),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .rd_en       (rd_en),
    .rdaddr      (rdaddr),
    .rddata      (rddata),
    .vsync       (vsync),
    .href        (href),
    .p_data      (p_data),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  initial p_clock = 1'b0;
  always #5 p_clock = ~p_clock;

  // One-cycle-latency frame buffer holding mem[a] = a ^ A5A5.
  always @(posedge p_clock) begin
    if (rd_en) rddata <= rdaddr[15:0] ^ 16'hA5A5;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, cur_t, got, exp);
    end
  endtask

  function automatic logic [15:0] pix_val(input logic [1:0] pat, input int l, input int n);
    int a;
    a = l * H + n;
    case (pat)
      2'd0:    return 16'(a) ^ 16'hA5A5;
      2'd1:    return bars[n / (H / 8)];
      2'd2:    return 16'(a);
      default: return 16'h0000;
    endcase
  endfunction

  // Expected outputs for cycle t of a frame, derived from the frame timeline.
  function automatic exp_t model(input int t, input logic [1:0] pat);
    exp_t        e;
    int          u;
    int          l;
    int          o;
    logic [15:0] p;
    e    = '0;
    e.bz = 1'b1;
    e.vs = (t < VS);
    e.fd = (t == FrameLen - VF);
    u = t - (VS + VB);
    if (u >= 0 && u < LinesLen) begin
      l = u / Pitch;
      o = u % Pitch;
      if (o < 2 * H) begin
        e.hr = 1'b1;
        p    = pix_val(pat, l, o / 2);
        e.pd = (o % 2 == 1) ? p[7:0] : p[15:8];
      end
    end
    u = u + 2;
    if (pat == 2'd0 && u >= 0 && u < LinesLen) begin
      l = u / Pitch;
      o = u % Pitch;
      if (o < 2 * H && o % 2 == 0) begin
        e.re = 1'b1;
        e.ra = 19'(l * H + o / 2);
      end
    end
    return e;
  endfunction

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge p_clock);
      #1;
      cur_t = -1;
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_vsync", 32'(vsync), 32'd0);
      check_eq("idle_href", 32'(href), 32'd0);
      check_eq("idle_pdata", 32'(p_data), 32'd0);
      check_eq("idle_rden", 32'(rd_en), 32'd0);
      check_eq("idle_rdaddr", 32'(rdaddr), 32'd0);
      check_eq("idle_fdone", 32'(frame_done), 32'd0);
    end
  endtask

  // Enable pulsed for one cycle from IDLE; returns on the edge that enters VSYNC.
  task automatic start_frame(input logic [1:0] pat);
    @(posedge p_clock);
    #1;
    enable      = 1'b1;
    pattern_sel = pat;
    @(posedge p_clock);
    #1;
    enable = 1'b0;
  endtask

  // Checks every cycle of one frame. Mid-frame enable/pattern_sel noise must not
  // affect the frame; the last cycle sets the values that decide the next frame.
  task automatic check_frame(input logic [1:0] pat, input bit hold, input logic [1:0] next_pat,
                             input bit noise, input int abort_at);
    exp_t e;
    for (int t = 0; t < FrameLen; t++) begin
      @(negedge p_clock);
      #1;
      cur_t = t;
      e = model(t, pat);
      check_eq("vsync", 32'(vsync), 32'(e.vs));
      check_eq("href", 32'(href), 32'(e.hr));
      check_eq("p_data", 32'(p_data), 32'(e.pd));
      check_eq("rd_en", 32'(rd_en), 32'(e.re));
      check_eq("frame_done", 32'(frame_done), 32'(e.fd));
      check_eq("busy", 32'(busy), 32'(e.bz));
      if (e.re) check_eq("rdaddr", 32'(rdaddr), 32'(e.ra));
      if (t == abort_at) begin
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_vsync", 32'(vsync), 32'd0);
        check_eq("rst_href", 32'(href), 32'd0);
        check_eq("rst_pdata", 32'(p_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rden", 32'(rd_en), 32'd0);
        enable = 1'b0;
        @(negedge p_clock);
        #2;
        rst_n = 1'b1;
        return;
      end
      if (t == FrameLen - 1) begin
        enable      = hold;
        pattern_sel = next_pat;
      end else if (noise) begin
        enable      = 1'($urandom_range(0, 1));
        pattern_sel = 2'($urandom_range(0, 3));
      end
    end
  endtask

  initial begin
    logic [1:0] pats [5];
    rst_n       = 1'b0;
    enable      = 1'b0;
    pattern_sel = 2'($urandom_range(0, 3));
    #1;
    cur_t = -2;
    check_eq("reset_vsync", 32'(vsync), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_rdaddr", 32'(rdaddr), 32'd0);
    repeat (3) @(negedge p_clock);
    #2;
    rst_n = 1'b1;
    check_idle(30);

    // Address ramp, enable pulsed once.
    start_frame(2'd2);
    check_frame(2'd2, 1'b0, 2'd0, 1'b0, -1);
    check_idle(5);

    // Colour bars with mid-frame input noise; frame must complete unchanged.
    start_frame(2'd1);
    check_frame(2'd1, 1'b0, 2'd0, 1'b1, -1);
    check_idle(5);

    // Back-to-back frames, first from the frame buffer, rest random.
    pats[0] = 2'd0;
    for (int i = 1; i < 5; i++) pats[i] = 2'($urandom_range(0, 3));
    start_frame(pats[0]);
    for (int i = 0; i < 5; i++) begin
      check_frame(pats[i], i < 4, (i < 4) ? pats[(i + 1) % 5] : 2'd0, 1'b1, -1);
    end
    check_idle(5);

    // Reset during an active line, then a clean frame.
    start_frame(2'd2);
    check_frame(2'd2, 1'b0, 2'd0, 1'b0, VS + VB + 2 * H + HB + 5);
    check_idle(10);
    start_frame(2'd0);
    check_frame(2'd0, 1'b0, 2'd0, 1'b1, -1);
    check_idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0d got=timeout exp=finish", cur_t);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dvp_camera_emulator.md
Name: dvp_camera_emulator

Overview:
Synthesizable OV7670-style DVP transmitter. It drives vsync, href and an 8-bit p_data byte stream in RGB565 format, two bytes per pixel, high byte first. Pixels come from a frame buffer read port or an internal test pattern. It stands in for the camera so that camera_read and the downstream frame-buffer/ILI9341 path can be exercised on hardware and in simulation without a sensor.

Parameters:
H_ACTIVE, 640, active pixels per line (2*H_ACTIVE bytes of href high per line)
V_ACTIVE, 480, active lines per frame
VSYNC_LEN, 20, cycles vsync is high at frame start
V_BACK, 34, cycles from vsync fall to first href rise
H_BLANK, 28, cycles href is low between consecutive lines
V_FRONT, 20, cycles from last href fall to next vsync rise

Ports:
p_clock  in  1  pixel/byte clock; one p_data byte per cycle
rst_n  in  1  asynchronous active-low reset
enable  in  1  start/continue frame generation
pattern_sel  in  2  0=frame buffer, 1=colour bars, 2=address ramp, 3=solid black
rd_en  out  1  frame buffer read strobe
rdaddr  out  19  frame buffer pixel address = line*H_ACTIVE + pixel
rddata  in  16  frame buffer pixel, valid 1 cycle after rd_en
vsync  out  1  frame sync, active high
href  out  1  line valid, active high
p_data  out  8  RGB565 byte stream
frame_done  out  1  one-cycle pulse after last byte of frame
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; vsync, href, p_data, rd_en, rdaddr, frame_done, busy all 0; counters cleared. Reset asserted mid-frame aborts the frame immediately. After release, emulator waits in IDLE for enable.
- Core logic runs on p_clock rising edge. vsync/href/p_data are re-registered on the falling edge, so they change half a cycle after the core and are stable at the receiver's rising-edge sample point.
- FSM states: IDLE, VSYNC, VBACK, LINE, HBLANK, VFRONT.
  - IDLE -> VSYNC when enable=1. pattern_sel is latched on this transition and held for the whole frame.
  - VSYNC: vsync=1 for VSYNC_LEN cycles, then VBACK.
  - VBACK: V_BACK cycles, then LINE.
  - LINE: href=1 for exactly 2*H_ACTIVE cycles; even byte = pixel[15:8], odd byte = pixel[7:0].
  - After LINE: go to HBLANK (H_BLANK cycles) then LINE, unless it was line V_ACTIVE-1; in that case go directly to VFRONT (no trailing HBLANK).
  - VFRONT: V_FRONT cycles, then VSYNC if enable=1, else IDLE.
- Frame length in cycles = VSYNC_LEN + V_BACK + V_ACTIVE*2*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + V_FRONT.
- Deasserting enable mid-frame does not truncate the frame; the current frame always completes.
- p_data = 0 whenever href=0.
- Counters:
  - byte counter 11 bits, 0..2*H_ACTIVE-1
  - line counter 9 bits, 0..V_ACTIVE-1
  - blank counter 16 bits, loaded per state
  - all wrap to 0 at their terminal count
- Frame buffer mode:
  - rd_en/rdaddr for pixel n are issued exactly 2 core cycles before the cycle carrying its high byte.
  - rddata is captured on the cycle after rd_en.
  - Prefetch of pixel 0 of each line falls in the last cycles of VBACK/HBLANK.
  - rdaddr increments linearly 0..H_ACTIVE*V_ACTIVE-1 across the frame and resets to 0 at VSYNC entry.
  - rd_en is never asserted outside these prefetch slots.
- Colour bars: 8 equal bars of H_ACTIVE/8 pixels, left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. rd_en stays 0.
- Address ramp: pixel = (line*H_ACTIVE + pixel)[15:0]. rd_en stays 0.
- Black: pixel = 0000. rd_en stays 0.
- frame_done: one-cycle pulse on the first VFRONT cycle. busy=1 from VSYNC entry until return to IDLE.
- enable=1 continuously: frames repeat back-to-back, separated only by VFRONT.

Test Plan:
1. Reset and idle: rst_n=0 then release with enable=0 -> all outputs 0, busy=0 indefinitely.
2. Small frame, ramp (H_ACTIVE=4, V_ACTIVE=2, pattern_sel=2, enable pulsed 1 cycle):
   - vsync high 20 cycles, then 34 cycles low before href.
   - line 0 bytes 00 00 00 01 00 02 00 03; 28 blank cycles; line 1 bytes 00 04 00 05 00 06 00 07.
   - frame_done 20 cycles before busy falls.
   - frame length 20+34+16+28+20 = 118 cycles.
3. Colour bars (H_ACTIVE=8, pattern_sel=1) -> line bytes FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00.
4. Frame buffer mode with a 1-cycle-latency RAM model holding mem[a]=a^16'hA5A5 (H_ACTIVE=640, V_ACTIVE=480):
   - rdaddr runs 0..307199.
   - every href byte pair equals the RAM word.
   - camera_read on the same bus yields pixel_data identical to the RAM model and wraddr 0..307199, plus its frame_done.
5. Enable dropped mid-line 1 of frame 0 -> frame completes, then IDLE. Enable held -> next vsync rises exactly V_FRONT cycles after the last href fall. pattern_sel changed mid-frame -> takes effect only on the next frame.
6. rst_n pulsed low during LINE -> href/p_data/vsync 0 within the same cycle, state IDLE. Next enable produces a full clean frame starting with vsync.
